buf_access_sched: RTL and testbench
===================================

# buf_access_sched

Packet-granular scheduler that sequences the shared free-list address manager of the PIFO packet buffer. It arbitrates enqueue traffic from NUM_PORTS write requesters round-robin and holds each grant for a whole packet. It serves one dequeue request at a time, walking the linked word chain. It drives the manager's wr_en / rd_en / rd_first_word_en / sop-address strobes, supplies the data-buffer word addresses, and emits a packet descriptor (sop address, length, port) per enqueued packet for the scheduler tree.

## Interface
Parameters:
- NUM_PORTS, 2: write requesters (2..8).
- ADDR_WIDTH, 12: buffer word-address width.
- LEN_WIDTH, 8: packet length field width, in words.

Ports:
- clk  in  1  clock.
- rstn  in  1  reset, synchronous, active-low.
- s_wr_valid  in  NUM_PORTS  per-port word valid.
- s_wr_last  in  NUM_PORTS  per-port last word of packet.
- s_wr_ready  out  NUM_PORTS  per-port ready; at most one bit set.
- s_rd_valid  in  1  dequeue request.
- s_rd_sop_addr  in  ADDR_WIDTH  sop address of packet to dequeue.
- s_rd_len  in  LEN_WIDTH  packet length in words; 0 treated as 1.
- s_rd_ready  out  1  dequeue request accepted when valid&ready.
- am_fl_head  in  ADDR_WIDTH  manager free-list head (current writable word).
- am_fl_tail_next  in  ADDR_WIDTH  manager next-tail (next linked read word).
- am_almost_full  in  1  manager almost-full.
- am_is_empty  in  1  manager empty.
- am_wr_en  out  1  manager write strobe.
- am_rd_en  out  1  manager read strobe.
- am_rd_first_word_en  out  1  manager first-read-word strobe.
- am_rd_pkt_sop_addr  out  ADDR_WIDTH  sop address for the first read word.
- m_wr_addr  out  ADDR_WIDTH  data-buffer write address.
- m_wr_port  out  clog2(NUM_PORTS)  granted port index.
- m_rd_addr  out  ADDR_WIDTH  data-buffer read address.
- m_rd_valid  out  1  m_rd_addr valid.
- m_rd_last  out  1  last read word.
- m_desc_valid  out  1  descriptor pulse.
- m_desc_sop_addr  out  ADDR_WIDTH  descriptor sop address.
- m_desc_len  out  LEN_WIDTH  descriptor length in words.
- m_desc_port  out  clog2(NUM_PORTS)  descriptor source port.

## Operation
Write FSM has two states, W_IDLE and W_PKT:
- W_IDLE: if any s_wr_valid and ~am_almost_full, grant the first valid port at or after rr_ptr, register g, and go to W_PKT. No ready in W_IDLE.
- W_PKT: s_wr_ready[g]=1. For each beat with valid[g]&ready:
  - am_wr_en=1 and m_wr_addr=am_fl_head (combinational, same cycle).
  - On the first beat, latch sop_addr=am_fl_head.
  - wcnt increments and saturates at 2^LEN_WIDTH-1.
- On the last beat, go to W_IDLE and set rr_ptr=(g+1) mod NUM_PORTS.
- am_almost_full is sampled only in W_IDLE. A packet in progress always completes.

Read FSM has three states, R_IDLE, R_FIRST and R_BODY:
- R_IDLE: s_rd_ready = ~am_is_empty. On accept, latch sop and len and go to R_FIRST.
- R_FIRST: assert am_rd_first_word_en, am_rd_en, m_rd_valid, with am_rd_pkt_sop_addr=m_rd_addr=sop. Set remaining count rcnt=len-1.
  - If rcnt==0, assert m_rd_last and go to R_IDLE.
  - Otherwise go to R_BODY.
- R_BODY: if ~am_is_empty, assert am_rd_en and m_rd_valid with m_rd_addr=am_fl_tail_next, then decrement rcnt.
  - The word that brings rcnt to 0 asserts m_rd_last and returns to R_IDLE.
  - If am_is_empty, stall with no strobes.

Write and read sides run independently; simultaneous am_wr_en and am_rd_en is legal.

## Timing
- Reset: all outputs 0, FSMs idle, rr_ptr=0. A reset mid-packet abandons the packet and emits no descriptor.
- Grant latency: first ready one cycle after the valid is seen in W_IDLE. There is one dead cycle between back-to-back packets.
- Write data path: am_wr_en and m_wr_addr are in the same cycle as the beat.
- Descriptor: m_desc_* is registered and valid exactly one cycle after the last beat. It has no backpressure.
  - m_desc_len = beat count.
  - m_desc_sop_addr = head at the first beat.
- Read latency: the first word strobes one cycle after the s_rd handshake. An N-word packet takes N strobe cycles with no stalls.
- s_rd_ready is low in R_FIRST and R_BODY; the next request is accepted one cycle after m_rd_last.

## Test plan
- Single port, 3-word packet, head sequence 0,1,2 -> am_wr_en for 3 cycles; m_wr_addr 0,1,2; desc (sop 0, len 3, port 0) one cycle after the last beat.
- Ports 0 and 1 both continuously valid with 2-word packets -> grants alternate 0,1,0,1; ready never overlaps; one idle cycle between packets.
- am_almost_full=1 during port 1's beat 2 of 4 -> all 4 beats complete; no new grant until almost_full=0.
- Dequeue sop=5, len=3, am_fl_tail_next 9 then 2 -> cycle 1: first_word_en+rd_en at addr 5; then rd_en at addr 9, then at addr 2 with m_rd_last.
- s_rd_len=0 and s_rd_len=1 -> exactly one first-word cycle with m_rd_last; s_rd_ready high on the next cycle.
- rstn low during W_PKT beat 2 -> next cycle all outputs 0, no m_desc_valid; port 0 is granted first afterward.

Source files
------------

// File: rtl/buf_access_sched.sv
// buf_access_sched: packet-granular sequencer for the PIFO buffer's free-list address manager.
//
// Ports:
//   clk, rstn            clock, synchronous active-low reset
//   s_wr_*               per-port enqueue word stream (valid/last in, one-hot ready out)
//   s_rd_*               dequeue request (sop address, length in words; 0 means 1)
//   am_*                 address-manager status in, write/read/first-word strobes out
//   m_wr_addr/m_wr_port  data-buffer write address and granted port
//   m_rd_*               data-buffer read address, valid, last word
//   m_desc_*             one-cycle packet descriptor (sop, length, port) after each packet
module buf_access_sched #(
    parameter int NUM_PORTS  = 2,
    parameter int ADDR_WIDTH = 12,
    parameter int LEN_WIDTH  = 8,
    localparam int PW        = $clog2(NUM_PORTS)
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [NUM_PORTS-1:0]  s_wr_valid,
    input  logic [NUM_PORTS-1:0]  s_wr_last,
    output logic [NUM_PORTS-1:0]  s_wr_ready,
    input  logic                  s_rd_valid,
    input  logic [ADDR_WIDTH-1:0] s_rd_sop_addr,
    input  logic [LEN_WIDTH-1:0]  s_rd_len,
    output logic                  s_rd_ready,
    input  logic [ADDR_WIDTH-1:0] am_fl_head,
    input  logic [ADDR_WIDTH-1:0] am_fl_tail_next,
    input  logic                  am_almost_full,
    input  logic                  am_is_empty,
    output logic                  am_wr_en,
    output logic                  am_rd_en,
    output logic                  am_rd_first_word_en,
    output logic [ADDR_WIDTH-1:0] am_rd_pkt_sop_addr,
    output logic [ADDR_WIDTH-1:0] m_wr_addr,
    output logic [PW-1:0]         m_wr_port,
    output logic [ADDR_WIDTH-1:0] m_rd_addr,
    output logic                  m_rd_valid,
    output logic                  m_rd_last,
    output logic                  m_desc_valid,
    output logic [ADDR_WIDTH-1:0] m_desc_sop_addr,
    output logic [LEN_WIDTH-1:0]  m_desc_len,
    output logic [PW-1:0]         m_desc_port
);

    typedef enum logic {W_IDLE, W_PKT} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_FIRST, R_BODY} r_state_t;

    w_state_t              w_state;
    r_state_t              r_state;
    logic [PW-1:0]         g;
    logic [PW-1:0]         rr_ptr;
    logic [LEN_WIDTH-1:0]  wcnt;
    logic [ADDR_WIDTH-1:0] sop_addr;
    logic [ADDR_WIDTH-1:0] rd_sop;
    logic [LEN_WIDTH-1:0]  rd_len;
    logic [LEN_WIDTH-1:0]  rcnt;

    // Round-robin pick: rotate valids so rr_ptr sits at bit 0, take the lowest set bit,
    // then add rr_ptr back modulo NUM_PORTS.
    logic [2*NUM_PORTS-1:0] rot_full;
    logic [PW-1:0]          off;
    logic [PW:0]            sum;
    logic [PW-1:0]          pick;

    always_comb begin
        rot_full = {s_wr_valid, s_wr_valid} >> rr_ptr;
        off = '0;
        for (int i = NUM_PORTS - 1; i >= 0; i--)
            if (rot_full[i]) off = PW'(i);
        sum = {1'b0, rr_ptr} + {1'b0, off};
        pick = (sum >= (PW+1)'(NUM_PORTS)) ? PW'(sum - (PW+1)'(NUM_PORTS)) : sum[PW-1:0];
    end

    logic                 wr_beat;
    logic [LEN_WIDTH-1:0] wcnt_inc;
    logic [PW-1:0]        g_next;

    assign wr_beat    = (w_state == W_PKT) && s_wr_valid[g];
    assign wcnt_inc   = (&wcnt) ? wcnt : wcnt + 1'b1;
    assign g_next     = (g == PW'(NUM_PORTS - 1)) ? '0 : g + 1'b1;
    assign s_wr_ready = (w_state == W_PKT) ? (NUM_PORTS'(1) << g) : '0;
    assign am_wr_en   = wr_beat;
    assign m_wr_addr  = wr_beat ? am_fl_head : '0;
    assign m_wr_port  = g;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            w_state         <= W_IDLE;
            g               <= '0;
            rr_ptr          <= '0;
            wcnt            <= '0;
            sop_addr        <= '0;
            m_desc_valid    <= 1'b0;
            m_desc_sop_addr <= '0;
            m_desc_len      <= '0;
            m_desc_port     <= '0;
        end else begin
            m_desc_valid <= 1'b0;
            if (w_state == W_IDLE) begin
                if (|s_wr_valid && !am_almost_full) begin
                    g       <= pick;
                    wcnt    <= '0;
                    w_state <= W_PKT;
                end
            end else if (wr_beat) begin
                if (wcnt == '0) sop_addr <= am_fl_head;
                wcnt <= wcnt_inc;
                if (s_wr_last[g]) begin
                    w_state         <= W_IDLE;
                    rr_ptr          <= g_next;
                    m_desc_valid    <= 1'b1;
                    // A one-word packet has its sop in the same beat, before sop_addr is loaded.
                    m_desc_sop_addr <= (wcnt == '0) ? am_fl_head : sop_addr;
                    m_desc_len      <= wcnt_inc;
                    m_desc_port     <= g;
                end
            end
        end
    end

    logic rd_first;
    logic rd_body;

    assign rd_first            = (r_state == R_FIRST);
    assign rd_body             = (r_state == R_BODY) && !am_is_empty;
    assign s_rd_ready          = rstn && (r_state == R_IDLE) && !am_is_empty;
    assign am_rd_first_word_en = rd_first;
    assign am_rd_en            = rd_first || rd_body;
    assign m_rd_valid          = rd_first || rd_body;
    assign am_rd_pkt_sop_addr  = rd_first ? rd_sop : '0;
    assign m_rd_addr           = rd_first ? rd_sop : rd_body ? am_fl_tail_next : '0;
    assign m_rd_last           = rd_first ? (rd_len <= LEN_WIDTH'(1)) : rd_body && (rcnt == LEN_WIDTH'(1));

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state <= R_IDLE;
            rd_sop  <= '0;
            rd_len  <= '0;
            rcnt    <= '0;
        end else begin
            case (r_state)
                R_IDLE: if (s_rd_valid && s_rd_ready) begin
                    rd_sop  <= s_rd_sop_addr;
                    rd_len  <= s_rd_len;
                    r_state <= R_FIRST;
                end
                R_FIRST: begin
                    rcnt    <= (rd_len == '0) ? '0 : rd_len - 1'b1;
                    r_state <= (rd_len <= LEN_WIDTH'(1)) ? R_IDLE : R_BODY;
                end
                R_BODY: if (rd_body) begin
                    rcnt <= rcnt - 1'b1;
                    if (rcnt == LEN_WIDTH'(1)) r_state <= R_IDLE;
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_buf_access_sched.sv
// tb_buf_access_sched: directed self-checking bench for buf_access_sched.
// Inputs change on the falling edge; outputs are checked shortly after, far from the rising edge.
module tb_buf_access_sched;

    logic        clk = 1'b0;
    logic        rstn;
    logic [1:0]  s_wr_valid, s_wr_last, s_wr_ready;
    logic        s_rd_valid;
    logic [11:0] s_rd_sop_addr;
    logic [7:0]  s_rd_len;
    logic        s_rd_ready;
    logic [11:0] am_fl_head, am_fl_tail_next;
    logic        am_almost_full, am_is_empty;
    logic        am_wr_en, am_rd_en, am_rd_first_word_en;
    logic [11:0] am_rd_pkt_sop_addr, m_wr_addr, m_rd_addr, m_desc_sop_addr;
    logic [0:0]  m_wr_port, m_desc_port;
    logic        m_rd_valid, m_rd_last, m_desc_valid;
    logic [7:0]  m_desc_len;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    buf_access_sched dut (
        .clk(clk), .rstn(rstn),
        .s_wr_valid(s_wr_valid), .s_wr_last(s_wr_last), .s_wr_ready(s_wr_ready),
        .s_rd_valid(s_rd_valid), .s_rd_sop_addr(s_rd_sop_addr), .s_rd_len(s_rd_len),
        .s_rd_ready(s_rd_ready),
        .am_fl_head(am_fl_head), .am_fl_tail_next(am_fl_tail_next),
        .am_almost_full(am_almost_full), .am_is_empty(am_is_empty),
        .am_wr_en(am_wr_en), .am_rd_en(am_rd_en), .am_rd_first_word_en(am_rd_first_word_en),
        .am_rd_pkt_sop_addr(am_rd_pkt_sop_addr),
        .m_wr_addr(m_wr_addr), .m_wr_port(m_wr_port),
        .m_rd_addr(m_rd_addr), .m_rd_valid(m_rd_valid), .m_rd_last(m_rd_last),
        .m_desc_valid(m_desc_valid), .m_desc_sop_addr(m_desc_sop_addr),
        .m_desc_len(m_desc_len), .m_desc_port(m_desc_port)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, " ready"}, 32'(s_wr_ready), 32'd0);
        chk({tag, " wr_en"}, 32'(am_wr_en), 32'd0);
        chk({tag, " wr_addr"}, 32'(m_wr_addr), 32'd0);
        chk({tag, " wr_port"}, 32'(m_wr_port), 32'd0);
        chk({tag, " rd_rdy"}, 32'(s_rd_ready), 32'd0);
        chk({tag, " rd_en"}, 32'(am_rd_en), 32'd0);
        chk({tag, " first"}, 32'(am_rd_first_word_en), 32'd0);
        chk({tag, " rd_valid"}, 32'(m_rd_valid), 32'd0);
        chk({tag, " rd_last"}, 32'(m_rd_last), 32'd0);
        chk({tag, " rd_addr"}, 32'(m_rd_addr), 32'd0);
        chk({tag, " desc_v"}, 32'(m_desc_valid), 32'd0);
        chk({tag, " desc_len"}, 32'(m_desc_len), 32'd0);
    endtask

    task automatic chk_beat(input string tag, input logic [1:0] rdy, input logic [11:0] addr, input logic port);
        chk({tag, " ready"}, 32'(s_wr_ready), 32'(rdy));
        chk({tag, " wr_en"}, 32'(am_wr_en), 32'd1);
        chk({tag, " wr_addr"}, 32'(m_wr_addr), 32'(addr));
        chk({tag, " wr_port"}, 32'(m_wr_port), 32'(port));
    endtask

    task automatic chk_desc(input string tag, input logic [11:0] sop, input logic [7:0] len, input logic port);
        chk({tag, " desc_v"}, 32'(m_desc_valid), 32'd1);
        chk({tag, " desc_sop"}, 32'(m_desc_sop_addr), 32'(sop));
        chk({tag, " desc_len"}, 32'(m_desc_len), 32'(len));
        chk({tag, " desc_port"}, 32'(m_desc_port), 32'(port));
    endtask

    task automatic chk_rd(input string tag, input logic first, input logic en, input logic [11:0] addr, input logic last);
        chk({tag, " first"}, 32'(am_rd_first_word_en), 32'(first));
        chk({tag, " rd_en"}, 32'(am_rd_en), 32'(en));
        chk({tag, " rd_valid"}, 32'(m_rd_valid), 32'(en));
        chk({tag, " rd_addr"}, 32'(m_rd_addr), 32'(addr));
        chk({tag, " rd_last"}, 32'(m_rd_last), 32'(last));
        chk({tag, " sop_out"}, 32'(am_rd_pkt_sop_addr), first ? 32'(addr) : 32'd0);
        chk({tag, " rd_rdy"}, 32'(s_rd_ready), 32'd0);
    endtask

    initial begin
        rstn = 1'b0; s_wr_valid = '0; s_wr_last = '0;
        s_rd_valid = 1'b0; s_rd_sop_addr = '0; s_rd_len = '0;
        am_fl_head = 12'h3ff; am_fl_tail_next = 12'h3fe;
        am_almost_full = 1'b0; am_is_empty = 1'b1;
        step(); step(); step();
        settle(); chk_quiet("reset");

        // Single-port 3-word packet, head 0,1,2.
        rstn = 1'b1; s_wr_valid = 2'b01; am_fl_head = 12'd0;
        settle(); chk("p0 idle ready", 32'(s_wr_ready), 32'd0);
        step(); settle(); chk_beat("p0 b1", 2'b01, 12'd0, 1'b0);
        step(); am_fl_head = 12'd1; settle(); chk_beat("p0 b2", 2'b01, 12'd1, 1'b0);
        step(); am_fl_head = 12'd2; s_wr_last = 2'b01; settle(); chk_beat("p0 b3", 2'b01, 12'd2, 1'b0);
        step(); s_wr_valid = 2'b00; s_wr_last = 2'b00; settle();
        chk_desc("p0 desc", 12'd0, 8'd3, 1'b0);
        chk("p0 post ready", 32'(s_wr_ready), 32'd0);
        chk("p0 post wr_en", 32'(am_wr_en), 32'd0);

        // Both ports continuously valid, 2-word packets; rr_ptr now points at port 1.
        step(); s_wr_valid = 2'b11; settle();
        chk("rr desc gone", 32'(m_desc_valid), 32'd0);
        chk("rr idle ready", 32'(s_wr_ready), 32'd0);
        step(); am_fl_head = 12'd3; settle(); chk_beat("rr p1 b1", 2'b10, 12'd3, 1'b1);
        step(); am_fl_head = 12'd4; s_wr_last = 2'b10; settle(); chk_beat("rr p1 b2", 2'b10, 12'd4, 1'b1);
        step(); s_wr_last = 2'b00; settle();
        chk("rr dead1", 32'(s_wr_ready), 32'd0);
        chk_desc("rr p1 desc", 12'd3, 8'd2, 1'b1);
        step(); am_fl_head = 12'd5; settle(); chk_beat("rr p0 b1", 2'b01, 12'd5, 1'b0);
        step(); am_fl_head = 12'd6; s_wr_last = 2'b01; settle(); chk_beat("rr p0 b2", 2'b01, 12'd6, 1'b0);
        step(); s_wr_last = 2'b00; settle();
        chk("rr dead2", 32'(s_wr_ready), 32'd0);
        chk_desc("rr p0 desc", 12'd5, 8'd2, 1'b0);

        // Port 1 4-word packet with almost_full rising at beat 2.
        step(); am_fl_head = 12'd7; settle(); chk_beat("af b1", 2'b10, 12'd7, 1'b1);
        step(); am_fl_head = 12'd8; am_almost_full = 1'b1; settle(); chk_beat("af b2", 2'b10, 12'd8, 1'b1);
        step(); am_fl_head = 12'd9; settle(); chk_beat("af b3", 2'b10, 12'd9, 1'b1);
        step(); am_fl_head = 12'd10; s_wr_last = 2'b10; settle(); chk_beat("af b4", 2'b10, 12'd10, 1'b1);
        step(); s_wr_last = 2'b00; settle();
        chk("af idle1", 32'(s_wr_ready), 32'd0);
        chk_desc("af desc", 12'd7, 8'd4, 1'b1);
        step(); settle();
        chk("af hold1", 32'(s_wr_ready), 32'd0);
        chk("af hold1 wr_en", 32'(am_wr_en), 32'd0);
        step(); settle();
        chk("af hold2", 32'(s_wr_ready), 32'd0);
        am_almost_full = 1'b0;
        step(); am_fl_head = 12'd11; settle(); chk_beat("af resume", 2'b01, 12'd11, 1'b0);

        // Reset during beat 2 of port 0's packet.
        step(); am_fl_head = 12'd12; rstn = 1'b0;
        step(); settle(); chk_quiet("midrst");
        rstn = 1'b1; settle(); chk("midrst idle", 32'(s_wr_ready), 32'd0);
        step(); am_fl_head = 12'd13; s_wr_last = 2'b01; s_wr_valid = 2'b01; settle();
        chk_beat("post rst p0", 2'b01, 12'd13, 1'b0);
        chk("post rst no desc", 32'(m_desc_valid), 32'd0);
        step(); s_wr_valid = 2'b00; s_wr_last = 2'b00; settle();
        chk_desc("one-word desc", 12'd13, 8'd1, 1'b0);

        // Dequeue sop=5 len=3, with one empty stall in the body.
        step(); am_is_empty = 1'b0; s_rd_valid = 1'b1; s_rd_sop_addr = 12'd5; s_rd_len = 8'd3;
        settle(); chk("rd idle ready", 32'(s_rd_ready), 32'd1);
        chk("rd idle rd_en", 32'(am_rd_en), 32'd0);
        step(); s_rd_valid = 1'b0; settle(); chk_rd("rd first", 1'b1, 1'b1, 12'd5, 1'b0);
        step(); am_fl_tail_next = 12'd9; settle(); chk_rd("rd body1", 1'b0, 1'b1, 12'd9, 1'b0);
        step(); am_is_empty = 1'b1; settle(); chk_rd("rd stall", 1'b0, 1'b0, 12'd0, 1'b0);
        step(); am_is_empty = 1'b0; am_fl_tail_next = 12'd2; settle(); chk_rd("rd body2", 1'b0, 1'b1, 12'd2, 1'b1);

        // Zero and one word lengths each take a single first-word cycle.
        step(); s_rd_valid = 1'b1; s_rd_sop_addr = 12'd7; s_rd_len = 8'd0; settle();
        chk("len0 ready", 32'(s_rd_ready), 32'd1);
        chk("len0 idle valid", 32'(m_rd_valid), 32'd0);
        step(); s_rd_valid = 1'b0; settle(); chk_rd("len0 first", 1'b1, 1'b1, 12'd7, 1'b1);
        step(); s_rd_valid = 1'b1; s_rd_sop_addr = 12'd8; s_rd_len = 8'd1; settle();
        chk("len1 ready", 32'(s_rd_ready), 32'd1);
        chk("len1 idle valid", 32'(m_rd_valid), 32'd0);
        step(); s_rd_valid = 1'b0; settle(); chk_rd("len1 first", 1'b1, 1'b1, 12'd8, 1'b1);
        step(); settle();
        chk("len1 after ready", 32'(s_rd_ready), 32'd1);
        chk("len1 after valid", 32'(m_rd_valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
